dmux8_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one 1-bit write/strobe path between 8 requesters. It picks one requester, holds the grant for a bounded number of cycles, and drives the 3-bit SEL and gated strobe into an internal DMux8Way instance. That DMux8Way decodes the one-hot grant vector. It sits in front of any resource reached through an 8-way demux, for example per-bank write enables in the memory map.

---
 rtl/dmux8_rr_scheduler.sv | 146 ++++++++++++++
 tb/tb_dmux8_rr_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dmux8_rr_scheduler.sv
// ============================================================================
// dmux8_rr_scheduler : round-robin scheduler sharing one strobe over an
//                      8-way demux. Optional LOCK input via DMUX_SCHED_LOCK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmux8_way (
    input  logic       IN,
    input  logic [2:0] SEL,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       G,
    output logic       H
);
    assign A = IN & (SEL == 3'd0);
    assign B = IN & (SEL == 3'd1);
    assign C = IN & (SEL == 3'd2);
    assign D = IN & (SEL == 3'd3);
    assign E = IN & (SEL == 3'd4);
    assign F = IN & (SEL == 3'd5);
    assign G = IN & (SEL == 3'd6);
    assign H = IN & (SEL == 3'd7);
endmodule

module dmux8_rr_scheduler #(
    parameter int HOLD_MAX = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] REQ,
`ifdef DMUX_SCHED_LOCK_EN
    input  logic       LOCK,
`endif
    output logic [2:0] SEL,
    output logic       STROBE,
    output logic [7:0] GNT,
    output logic       BUSY
);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q;

    logic       found;
    logic [2:0] pick;
    logic [2:0] cand;
    logic       release_grant;
    logic       lock_hold;

`ifdef DMUX_SCHED_LOCK_EN
    assign lock_hold = LOCK;
`else
    assign lock_hold = 1'b0;
`endif

    // Search starts just after the last winner, so it is considered last.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        cand  = '0;
        for (int k = 1; k <= 8; k++) begin
            cand = last_q + 3'(k);
            if (!found && REQ[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        release_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                release_grant = !REQ[sel_q] || ((cnt_q == HOLD_LAST) && !lock_hold);
                if (release_grant) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != HOLD_LAST) begin
                    // Under LOCK the counter parks at the limit.
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            last_q  <= 3'd7;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == GRANT);
        end
    end

    assign SEL    = sel_q;
    assign BUSY   = busy_q;
    assign STROBE = (state_q == GRANT) && REQ[sel_q];

    dmux8_way u_dmux (
        .IN  (STROBE),
        .SEL (sel_q),
        .A   (GNT[0]),
        .B   (GNT[1]),
        .C   (GNT[2]),
        .D   (GNT[3]),
        .E   (GNT[4]),
        .F   (GNT[5]),
        .G   (GNT[6]),
        .H   (GNT[7])
    );
endmodule

`default_nettype wire

// File: tb/tb_dmux8_rr_scheduler.sv
// ============================================================================
// tb_dmux8_rr_scheduler : directed vector bench for dmux8_rr_scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dmux8_rr_scheduler;
    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] sel;
    logic       strobe;
    logic [7:0] gnt;
    logic       busy;

    logic       rst2_n;
    logic [7:0] req2;
    logic       lock;
    logic [2:0] sel2;
    logic       strobe2;
    logic [7:0] gnt2;
    logic       busy2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmux8_rr_scheduler #(.HOLD_MAX(4)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .REQ     (req),
`ifdef DMUX_SCHED_LOCK_EN
        .LOCK    (1'b0),
`endif
        .SEL     (sel),
        .STROBE  (strobe),
        .GNT     (gnt),
        .BUSY    (busy)
    );

    dmux8_rr_scheduler #(.HOLD_MAX(2)) dut2 (
        .CLK     (clk),
        .RESET_N (rst2_n),
        .REQ     (req2),
`ifdef DMUX_SCHED_LOCK_EN
        .LOCK    (lock),
`endif
        .SEL     (sel2),
        .STROBE  (strobe2),
        .GNT     (gnt2),
        .BUSY    (busy2)
    );

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic       chk;
        logic [2:0] sel;
        logic       strobe;
        logic [7:0] gnt;
        logic       busy;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_all(input string tag, input logic [2:0] esel, input logic estb,
                             input logic [7:0] egnt, input logic ebusy);
        check({tag, " sel"},    {5'd0, sel},    {5'd0, esel});
        check({tag, " strobe"}, {7'd0, strobe}, {7'd0, estb});
        check({tag, " gnt"},    gnt,            egnt);
        check({tag, " busy"},   {7'd0, busy},   {7'd0, ebusy});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // rst_n, req, chk, sel, strobe, gnt, busy (outputs seen before the edge)
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1};
        vecs[4]  = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1};
        vecs[5]  = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1};
        vecs[6]  = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1};
        vecs[7]  = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, 8'h01, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1};
        vecs[9]  = '{1'b1, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1};
        vecs[10] = '{1'b1, 8'h24, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
        vecs[11] = '{1'b1, 8'h24, 1'b1, 3'd2, 1'b1, 8'h04, 1'b1};
        vecs[12] = '{1'b1, 8'h20, 1'b1, 3'd2, 1'b0, 8'h00, 1'b1};
        vecs[13] = '{1'b1, 8'h24, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0};
        vecs[14] = '{1'b1, 8'h24, 1'b1, 3'd5, 1'b1, 8'h20, 1'b1};
        vecs[15] = '{1'b1, 8'h24, 1'b1, 3'd5, 1'b1, 8'h20, 1'b1};
        vecs[16] = '{1'b0, 8'h24, 1'b1, 3'd5, 1'b1, 8'h20, 1'b1};
        vecs[17] = '{1'b1, 8'h41, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
        vecs[18] = '{1'b1, 8'h41, 1'b1, 3'd0, 1'b1, 8'h01, 1'b1};

        rst_n  = 1'b0;
        req    = 8'h00;
        rst2_n = 1'b0;
        req2   = 8'h00;
        lock   = 1'b0;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n;
            req   = vecs[i].req;
            #1;
            if (vecs[i].chk)
                check_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].strobe,
                          vecs[i].gnt, vecs[i].busy);
        end

        // All requesting: grants rotate 0..7,0, four beats each, one dead cycle between.
        @(negedge clk); rst_n = 1'b0; req = 8'h00;
        @(negedge clk); rst_n = 1'b1; req = 8'hFF; #1;
        check_all("ff_idle0", 3'd0, 1'b0, 8'h00, 1'b0);
        for (int g = 0; g < 9; g++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk); #1;
                check($sformatf("ff_g%0d_c%0d gnt", g, c), gnt, 8'(1 << (g % 8)));
                check($sformatf("ff_g%0d_c%0d sel", g, c), {5'd0, sel}, 8'(g % 8));
            end
            @(negedge clk); #1;
            check($sformatf("ff_g%0d dead gnt", g), gnt, 8'h00);
            check($sformatf("ff_g%0d dead busy", g), {7'd0, busy}, 8'h00);
        end

        // Reset while requester 6 is mid-grant at CNT=2; pointer must return to 7.
        @(negedge clk); rst_n = 1'b0; req = 8'h00;
        @(negedge clk); rst_n = 1'b1; req = 8'h40; #1;
        check_all("mid_idle", 3'd0, 1'b0, 8'h00, 1'b0);
        @(negedge clk); #1; check_all("mid_c0", 3'd6, 1'b1, 8'h40, 1'b1);
        @(negedge clk); #1; check_all("mid_c1", 3'd6, 1'b1, 8'h40, 1'b1);
        @(negedge clk); rst_n = 1'b0; #1;
        check_all("mid_c2", 3'd6, 1'b1, 8'h40, 1'b1);
        @(negedge clk); rst_n = 1'b1; req = 8'h41; #1;
        check_all("mid_after_rst", 3'd0, 1'b0, 8'h00, 1'b0);
        @(negedge clk); #1; check_all("mid_regrant", 3'd0, 1'b1, 8'h01, 1'b1);

        // HOLD_MAX=2 instance, REQ[4] held with LOCK=1 for 10 cycles.
        @(negedge clk); rst2_n = 1'b0;
        @(negedge clk); rst2_n = 1'b1; req2 = 8'h10; lock = 1'b1; #1;
        check("lock idle gnt", gnt2, 8'h00);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
`ifdef DMUX_SCHED_LOCK_EN
            check($sformatf("lock k%0d gnt", k), gnt2, 8'h10);
`else
            check($sformatf("hold2 k%0d gnt", k), gnt2, ((k % 3) == 2) ? 8'h00 : 8'h10);
`endif
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // GNT must never be multi-hot.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && !$onehot0(gnt)) begin
            total_cnt++;
            $display("FAIL onehot: got %0h expected one-hot or zero", gnt);
        end
    end
endmodule

`default_nettype wire
